// File: rtl/instr_seq_ctrl_pkg.sv
// +--------------------------------------------------------------------+
// | instr_seq_ctrl_pkg: states, opcodes and ISA field slices            |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package instr_seq_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_FETCH  = 3'd1;
  localparam state_t ST_DECODE = 3'd2;
  localparam state_t ST_EXEC   = 3'd3;
  localparam state_t ST_WB     = 3'd4;
  localparam state_t ST_HALTED = 3'd5;

  localparam logic [1:0] OP_MOV = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_LDI = 2'b10;
  localparam logic [1:0] OP_JMP = 2'b11;

  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 6;
  localparam int RD_MSB  = 5;
  localparam int RD_LSB  = 3;
  localparam int RS_MSB  = 2;
  localparam int RS_LSB  = 0;
  localparam int IMM_MSB = 5;
  localparam int IMM_LSB = 0;

  function automatic logic is_jump(input logic [7:0] instr);
    return instr[OPC_MSB:OPC_LSB] == OP_JMP;
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_seq_ctrl_pc_next_unit.sv
// +--------------------------------------------------------------------+
// | pc_next_unit: next PC, either pc+1 or pc+1+imm, modulo 2^PC_W       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module pc_next_unit #(
  parameter int PC_W = 8
) (
  input  logic [PC_W-1:0] pc,
  input  logic [5:0]      imm,
  input  logic            jump,
  output logic [PC_W-1:0] next_pc
);

  logic [PC_W-1:0] imm_ext;

  // Zero-extended offset; natural truncation of the sum gives the wrap.
  assign imm_ext = jump ? PC_W'(imm) : '0;
  assign next_pc = pc + PC_W'(1) + imm_ext;

endmodule

`default_nettype wire

// File: rtl/instr_seq_ctrl.sv
// +--------------------------------------------------------------------+
// | instr_seq_ctrl: FETCH/DECODE/EXEC/WB sequencer owning PC and IR     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module instr_seq_ctrl
  import instr_seq_ctrl_pkg::*;
#(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt_req,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [7:0]       imem_rdata,
  output logic [7:0]       ir,
  output logic [2:0]       rf_raddr_a,
  output logic [2:0]       rf_raddr_b,
  output logic [1:0]       alu_op,
  output logic             rf_we,
  output logic [2:0]       rf_waddr,
  output logic [PC_W-1:0]  pc,
  output logic             running,
  output logic [CNT_W-1:0] retired
);

  state_t          state;
  state_t          boundary_state;
  logic [PC_W-1:0] next_pc;
  logic            ir_jump;

  assign ir_jump = is_jump(ir);

  pc_next_unit #(
    .PC_W (PC_W)
  ) u_pc_next (
    .pc      (pc),
    .imm     (ir[IMM_MSB:IMM_LSB]),
    .jump    (ir_jump),
    .next_pc (next_pc)
  );

  // Only the halt_req level on the edge that retires an instruction matters.
  assign boundary_state = halt_req ? ST_HALTED : ST_FETCH;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      pc      <= '0;
      ir      <= '0;
      retired <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (imem_ack) begin
            ir    <= imem_rdata;
            state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (ir_jump) begin
            pc      <= next_pc;
            retired <= retired + CNT_W'(1);
            state   <= boundary_state;
          end else begin
            state <= ST_WB;
          end
        end
        ST_WB: begin
          pc      <= next_pc;
          retired <= retired + CNT_W'(1);
          state   <= boundary_state;
        end
        ST_HALTED: begin
          if (start && !halt_req) state <= ST_FETCH;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign imem_req   = (state == ST_FETCH);
  assign imem_addr  = pc;
  assign rf_raddr_a = ir[RD_MSB:RD_LSB];
  assign rf_raddr_b = ir[RS_MSB:RS_LSB];
  assign alu_op     = (state == ST_EXEC) ? ir[OPC_MSB:OPC_LSB] : OP_MOV;
  assign rf_we      = (state == ST_WB);
  assign rf_waddr   = ir[RD_MSB:RD_LSB];
  assign running    = (state == ST_FETCH) || (state == ST_DECODE) ||
                      (state == ST_EXEC)  || (state == ST_WB);

endmodule

`default_nettype wire

// File: tb/tb_instr_seq_ctrl.sv
// +--------------------------------------------------------------------+
// | tb_instr_seq_ctrl: table vectors, hand sequences and random program |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_instr_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        halt_req;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [7:0]  imem_rdata;
  logic [7:0]  ir;
  logic [2:0]  rf_raddr_a;
  logic [2:0]  rf_raddr_b;
  logic [1:0]  alu_op;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [7:0]  pc;
  logic        running;
  logic [15:0] retired;

  int checks = 0;
  int errors = 0;

  logic [7:0]  m_pc;
  logic [15:0] m_ret;

  typedef struct {
    logic [7:0] instr;
    int         waitc;
    logic       halt;
    logic [7:0] exp_pc;
  } vec_t;

  vec_t tbl[16];

  instr_seq_ctrl #(.PC_W(8), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .halt_req   (halt_req),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .ir         (ir),
    .rf_raddr_a (rf_raddr_a),
    .rf_raddr_b (rf_raddr_b),
    .alu_op     (alu_op),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .pc         (pc),
    .running    (running),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Architectural next-PC rule: plain integer arithmetic modulo 256.
  function automatic logic [7:0] ref_next(input logic [7:0] p, input logic [7:0] instr);
    int n;
    n = int'(p) + 1;
    if (instr[7:6] == 2'b11) n = n + int'(instr[5:0]);
    return 8'(n % 256);
  endfunction

  // Entered just after the edge that put the DUT into FETCH.
  task automatic run_instr(input logic [7:0] instr, input int waitc,
                           input logic halt, input logic [7:0] exp_pc);
    logic jmp;
    jmp = (instr[7:6] == 2'b11);
    for (int i = 0; i <= waitc; i++) begin
      chk("fetch_req", imem_req, 1);
      chk("fetch_addr", imem_addr, m_pc);
      chk("fetch_we", rf_we, 0);
      imem_ack   = (i == waitc);
      imem_rdata = (i == waitc) ? instr : 8'($urandom);
      step();
    end
    // Stray acks outside FETCH must not touch ir.
    imem_ack   = 1'($urandom);
    imem_rdata = ~instr;
    chk("dec_ir", ir, instr);
    chk("dec_raddr", {rf_raddr_a, rf_raddr_b}, instr[5:0]);
    chk("dec_req", imem_req, 0);
    halt_req = ~halt;
    step();
    imem_ack = 1'b0;
    chk("exec_ir", ir, instr);
    chk("exec_alu", alu_op, instr[7:6]);
    chk("exec_we", rf_we, 0);
    chk("exec_pc", pc, m_pc);
    halt_req = jmp ? halt : ~halt;
    if (!jmp) begin
      step();
      halt_req = halt;
      chk("wb_we", rf_we, 1);
      chk("wb_waddr", rf_waddr, instr[5:3]);
      chk("wb_alu", alu_op, 0);
    end
    step();
    m_ret = m_ret + 16'd1;
    m_pc  = exp_pc;
    chk("pc", pc, m_pc);
    chk("retired", retired, m_ret);
    chk("post_we", rf_we, 0);
    chk("boundary", {running, imem_req}, halt ? 2'b00 : 2'b11);
    if (halt) begin
      start = 1'b1;
      step();
      step();
      chk("halt_hold_run", running, 0);
      chk("halt_hold_pc", pc, m_pc);
      chk("halt_hold_ir", ir, instr);
      halt_req = 1'b0;
      step();
      start = 1'b0;
      chk("resume_req", imem_req, 1);
      chk("resume_addr", imem_addr, m_pc);
    end
    halt_req = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{8'h4A, 0, 1'b0, 8'd1};
    tbl[1]  = '{8'h00, 0, 1'b0, 8'd2};
    tbl[2]  = '{8'h81, 3, 1'b0, 8'd3};
    tbl[3]  = '{8'hC5, 0, 1'b0, 8'd9};
    tbl[4]  = '{8'hC0, 1, 1'b0, 8'd10};
    tbl[5]  = '{8'h7F, 0, 1'b1, 8'd11};
    tbl[6]  = '{8'hFF, 0, 1'b0, 8'd75};
    tbl[7]  = '{8'hFF, 2, 1'b0, 8'd139};
    tbl[8]  = '{8'hFF, 0, 1'b0, 8'd203};
    tbl[9]  = '{8'hEE, 0, 1'b0, 8'd250};
    tbl[10] = '{8'hCA, 0, 1'b0, 8'd5};
    tbl[11] = '{8'hFF, 0, 1'b0, 8'd69};
    tbl[12] = '{8'hFF, 0, 1'b0, 8'd133};
    tbl[13] = '{8'hFF, 0, 1'b0, 8'd197};
    tbl[14] = '{8'hF9, 0, 1'b0, 8'd255};
    tbl[15] = '{8'h4A, 1, 1'b0, 8'd0};

    reset      = 1'b0;
    start      = 1'b0;
    halt_req   = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 8'h00;
    m_pc       = 8'd0;
    m_ret      = 16'd0;
    step();
    step();
    reset = 1'b1;
    step();
    chk("rst_pc", pc, 0);
    chk("rst_ir", ir, 0);
    chk("rst_retired", retired, 0);
    chk("rst_outs", {imem_req, rf_we, running, alu_op}, 0);
    imem_ack = 1'b1;
    step();
    chk("idle_ignores_ack", {imem_req, ir}, 0);
    imem_ack = 1'b0;

    start = 1'b1;
    step();
    start = 1'b0;
    foreach (tbl[k]) run_instr(tbl[k].instr, tbl[k].waitc, tbl[k].halt, tbl[k].exp_pc);

    for (int n = 0; n < 300; n++) begin
      logic [7:0] ins;
      ins = 8'($urandom);
      run_instr(ins, $urandom_range(0, 3), ($urandom_range(0, 9) == 0), ref_next(m_pc, ins));
    end

    // Reset in the middle of a fetch with the ack already on the bus.
    chk("pre_rst_fetch", imem_req, 1);
    imem_ack   = 1'b1;
    imem_rdata = 8'h4A;
    #2 reset = 1'b0;
    #1;
    chk("async_rst_pc", pc, 0);
    chk("async_rst_ir", ir, 0);
    chk("async_rst_ret", retired, 0);
    chk("async_rst_outs", {imem_req, rf_we, running, alu_op}, 0);
    step();
    reset = 1'b1;
    step();
    step();
    chk("rst_ack_ignored", {imem_req, running, ir, pc}, 0);
    imem_ack = 1'b0;
    m_pc     = 8'd0;
    m_ret    = 16'd0;
    start    = 1'b1;
    step();
    start = 1'b0;
    run_instr(8'h4A, 0, 1'b0, 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/instr_seq_ctrl.md
Name: instr_seq_ctrl

Overview:
- Multi-cycle control sequencer for the 8-bit core.
- Owns the program counter and the instruction register.
- Fetches instructions from instruction memory over a req/ack handshake, then decodes them.
- Drives register-file and ALU control strobes through a FETCH/DECODE/EXEC/WB state machine.
- Resolves relative jumps and stops cleanly at instruction boundaries on request.

Parameters:
- PC_W, 8, program counter / instruction address width.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low.
- start  in  1  level; leaves IDLE/HALTED and begins fetching.
- halt_req  in  1  level; stop at the next instruction boundary.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  PC_W  fetch address (equals PC).
- imem_ack  in  1  instruction memory has valid data this cycle.
- imem_rdata  in  8  instruction byte, valid when imem_ack=1.
- ir  out  8  latched instruction register.
- rf_raddr_a  out  3  register-file read address A = ir[5:3].
- rf_raddr_b  out  3  register-file read address B = ir[2:0].
- alu_op  out  2  ALU operation = ir[7:6], valid in EXEC.
- rf_we  out  1  register-file write strobe, one cycle in WB.
- rf_waddr  out  3  write address = ir[5:3].
- pc  out  PC_W  current program counter.
- running  out  1  1 in FETCH/DECODE/EXEC/WB.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- ISA fields: opcode = ir[7:6], imm = ir[5:0].
  - Opcodes 00/01/10 are register ops with writeback.
  - Opcode 11 is a relative jump: PC <= PC + 1 + imm, zero-extended imm, modulo 2^PC_W.
  - A jump performs no writeback.
- Reset (async, reset=0):
  - State = IDLE; pc = 0, ir = 0, retired = 0.
  - imem_req = rf_we = running = 0; alu_op = 0.
  - Reset asserted mid-fetch aborts immediately; an ack arriving afterwards is ignored.
- IDLE: wait. start=1 -> FETCH on the next edge.
- FETCH:
  - imem_req = 1, imem_addr = pc, held stable until imem_ack.
  - On the edge where imem_ack=1: ir <= imem_rdata -> DECODE.
  - Ack in the same cycle as req is legal, so the minimum FETCH is 1 cycle.
  - imem_ack outside FETCH is ignored.
- DECODE: one cycle. rf_raddr_a/b are combinational from ir and valid from DECODE onward. -> EXEC.
- EXEC: alu_op = ir[7:6].
  - Opcode 11: pc <= pc + 1 + imm; retired <= retired + 1; then -> boundary check.
  - Otherwise: -> WB.
- WB:
  - rf_we = 1 for exactly one cycle, rf_waddr = ir[5:3].
  - pc <= pc + 1; retired <= retired + 1; then -> boundary check.
- Boundary check (same edge that leaves EXEC-jump or WB): halt_req=1 -> HALTED, else -> FETCH.
- halt_req asserted mid-instruction:
  - The instruction completes normally.
  - Only the level sampled at the boundary edge matters.
- HALTED:
  - running = 0; pc and ir are held.
  - start=1 and halt_req=0 -> FETCH, resuming at the held pc.
  - start=1 with halt_req=1 stays in HALTED.
- Latency, zero-wait memory: register op = 4 cycles (F, D, E, W); jump = 3 cycles (F, D, E).
- Each wait cycle on imem_ack adds 1 cycle.
- Wrap-around:
  - pc 255 + 1 -> 0.
  - Jump from 250 with imm=10 -> 261 mod 256 = 5.
  - retired wraps at 2^CNT_W.
- rf_we is never asserted outside WB; imem_req is never asserted outside FETCH.

Decomposition:
- Shared package holds:
  - state enum (IDLE, FETCH, DECODE, EXEC, WB, HALTED);
  - opcode constants OP_MOV=00, OP_ADD=01, OP_LDI=10, OP_JMP=11;
  - field slice positions for opcode, rd, rs, imm.
- One sub-module, pc_next_unit: combinational next-PC (pc+1 or pc+1+imm), keeping the modulo arithmetic in one place.
- The FSM and registers stay in instr_seq_ctrl.

Test Plan:
- Reset then start, zero-wait memory, mem[0]=8'h4A (ADD r1,r2):
  - imem_req in cycle 1; rf_we=1 with rf_waddr=1 in cycle 4; pc=1, retired=1 after cycle 4.
  - Next imem_req in cycle 5.
- mem[3]=8'hC5 (JMP +5) at pc=3:
  - After EXEC, pc=9; no rf_we pulse; 3-cycle instruction; retired increments by 1.
- imem_ack delayed 3 cycles:
  - imem_req and imem_addr stay stable for 4 cycles; ir loads only on the ack edge; instruction takes 7 cycles.
- halt_req raised in DECODE of an ADD at pc=7:
  - WB still completes (rf_we pulse, pc=8); state goes HALTED with running=0.
  - A later start with halt_req=0 fetches from address 8.
- Wrap: pc=250, mem[250]=8'hCA (JMP +10) -> pc=5. Separately, a register op at pc=255 -> pc=0.
- Reset asserted mid-FETCH with a pending ack:
  - All outputs return to reset values immediately; the ack is ignored; no fetch occurs until start.
